// File: rtl/tlc_req_front.sv
// Traffic-light request front end: synchronizes and debounces the NS, EW and pedestrian
// sensors, latches the pedestrian request, and (with TLC_PED_AGE_EN) flags an aged request.
module tlc_req_front #(
    parameter int DEB_CYC  = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_ns,
    input  logic raw_ew,
    input  logic raw_ped,
    input  logic walk,
    output logic NS,
    output logic EW,
    output logic Pedestrian,
    output logic ped_urgent
);

    if (DEB_CYC < 1 || DEB_CYC > 255 || MAX_WAIT < 1 || MAX_WAIT > 65535) begin : g_bad_param
        $error("tlc_req_front: DEB_CYC must be 1..255 and MAX_WAIT 1..65535");
    end

    localparam int          N_CH     = 3;
    localparam int          CH_PED   = 2;
    localparam logic [7:0]  DEB_LAST = 8'(DEB_CYC - 1);

    logic [N_CH-1:0] w_raw;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_filt;
    logic [7:0]      r_cnt [N_CH];
    logic            r_ped_prev;
    logic            r_ped;
    logic            w_ped_rise;

    assign w_raw = {raw_ped, raw_ew, raw_ns};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would collapse the two synchronizer stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The toggle fires on the edge the counter would reach DEB_CYC, so a stable change
    // reaches r_filt 2 (sync) + DEB_CYC edges after it is first sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
            // element by element; a reset mid-debounce must discard partial counts.
            for (int c = 0; c < N_CH; c++) r_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (r_sync2[c] == r_filt[c]) begin
                    r_cnt[c] <= '0;
                end else if (r_cnt[c] == DEB_LAST) begin
                    r_filt[c] <= ~r_filt[c];
                    r_cnt[c]  <= '0;
                end else if (r_cnt[c] != 8'hFF) begin
                    r_cnt[c] <= r_cnt[c] + 8'd1;
                end
            end
        end
    end

    assign w_ped_rise = r_filt[CH_PED] & ~r_ped_prev;

    // Walk is checked first so a request arriving during service is dropped, not queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ped_prev <= 1'b0;
            r_ped      <= 1'b0;
        end else begin
            r_ped_prev <= r_filt[CH_PED];
            if (walk) begin
                r_ped <= 1'b0;
            end else if (w_ped_rise) begin
                r_ped <= 1'b1;
            end
        end
    end

`ifdef TLC_PED_AGE_EN
    localparam logic [15:0] AGE_MAX = 16'(MAX_WAIT);

    logic [15:0] r_age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_age <= '0;
        end else if (walk) begin
            r_age <= '0;
        end else if (r_ped && (r_age != AGE_MAX)) begin
            r_age <= r_age + 16'd1;
        end
    end

    assign ped_urgent = (r_age == AGE_MAX);
`else
    assign ped_urgent = 1'b0;
`endif

    assign NS         = r_filt[0];
    assign EW         = r_filt[1];
    assign Pedestrian = r_ped;

endmodule

// File: tb/tb_tlc_req_front.sv
// Directed bench for tlc_req_front (DEB_CYC=4, MAX_WAIT=8); aging checks follow TLC_PED_AGE_EN.
module tb_tlc_req_front;

    logic clk = 1'b0;
    logic rst;
    logic raw_ns, raw_ew, raw_ped, walk;
    logic NS, EW, Pedestrian, ped_urgent;

    int errors = 0;
    int checks = 0;

    tlc_req_front #(.DEB_CYC(4), .MAX_WAIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_ns     (raw_ns),
        .raw_ew     (raw_ew),
        .raw_ped    (raw_ped),
        .walk       (walk),
        .NS         (NS),
        .EW         (EW),
        .Pedestrian (Pedestrian),
        .ped_urgent (ped_urgent)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        raw_ns = 1'b1;
        tick(3);
        checks++; if (NS !== 1'b0) begin errors++; $display("FAIL reset_ns: got %b want 0", NS); end
        checks++; if (EW !== 1'b0) begin errors++; $display("FAIL reset_ew: got %b want 0", EW); end
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL reset_ped: got %b want 0", Pedestrian); end
        checks++; if (ped_urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %b want 0", ped_urgent); end
        rst = 1'b1;
        tick(5);
        checks++; if (NS !== 1'b0) begin errors++; $display("FAIL reset_ns_early: got %b want 0 at edge 5", NS); end
        tick(1);
        checks++; if (NS !== 1'b1) begin errors++; $display("FAIL reset_ns_rise: got %b want 1 at edge 6", NS); end
    endtask

    task automatic test_glitch;
        raw_ew = 1'b1;
        tick(2);
        raw_ew = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++; if (EW !== 1'b0) begin errors++; $display("FAIL glitch_ew cyc %0d: got %b want 0", i, EW); end
        end
        raw_ew = 1'b1;
        tick(5);
        checks++; if (EW !== 1'b0) begin errors++; $display("FAIL ew_early: got %b want 0 at edge 5", EW); end
        tick(1);
        checks++; if (EW !== 1'b1) begin errors++; $display("FAIL ew_rise: got %b want 1 at edge 6", EW); end
        tick(4);
        checks++; if (EW !== 1'b1) begin errors++; $display("FAIL ew_hold: got %b want 1", EW); end
    endtask

    task automatic test_bouncy_button;
        for (int i = 0; i < 6; i++) begin
            raw_ped = (i % 2 == 0);
            tick(1);
            checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL bounce_ped cyc %0d: got %b want 0", i, Pedestrian); end
        end
        raw_ped = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL bounce_settle edge %0d: got %b want 0", i, Pedestrian); end
        end
        tick(1);
        checks++; if (Pedestrian !== 1'b1) begin errors++; $display("FAIL bounce_set: got %b want 1 at edge 7", Pedestrian); end
        tick(3);
        checks++; if (Pedestrian !== 1'b1) begin errors++; $display("FAIL bounce_hold: got %b want 1", Pedestrian); end
        walk = 1'b1;
        tick(1);
        walk = 1'b0;
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL walk_clear: got %b want 0", Pedestrian); end
        tick(4);
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL held_no_reset: got %b want 0", Pedestrian); end
        raw_ped = 1'b0;
        tick(8);
        raw_ped = 1'b1;
        tick(6);
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL repress_early: got %b want 0", Pedestrian); end
        tick(1);
        checks++; if (Pedestrian !== 1'b1) begin errors++; $display("FAIL repress_set: got %b want 1", Pedestrian); end
        walk = 1'b1;
        tick(1);
        walk = 1'b0;
        raw_ped = 1'b0;
        tick(8);
    endtask

    task automatic test_collision;
        raw_ped = 1'b1;
        tick(6);
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL coll_pre: got %b want 0", Pedestrian); end
        walk = 1'b1;
        tick(1);
        walk = 1'b0;
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL coll_edge: got %b want 0", Pedestrian); end
        tick(3);
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL coll_after: got %b want 0", Pedestrian); end
        raw_ped = 1'b0;
        tick(8);
    endtask

    task automatic test_aging;
        logic exp_urg;
`ifdef TLC_PED_AGE_EN
        exp_urg = 1'b1;
`else
        exp_urg = 1'b0;
`endif
        raw_ped = 1'b1;
        tick(7);
        checks++; if (Pedestrian !== 1'b1) begin errors++; $display("FAIL age_ped_set: got %b want 1", Pedestrian); end
        checks++; if (ped_urgent !== 1'b0) begin errors++; $display("FAIL age_start: got %b want 0", ped_urgent); end
        tick(7);
        checks++; if (ped_urgent !== 1'b0) begin errors++; $display("FAIL age_7: got %b want 0", ped_urgent); end
        tick(1);
        checks++; if (ped_urgent !== exp_urg) begin errors++; $display("FAIL age_8: got %b want %b", ped_urgent, exp_urg); end
        tick(3);
        checks++; if (ped_urgent !== exp_urg) begin errors++; $display("FAIL age_sat: got %b want %b", ped_urgent, exp_urg); end
        walk = 1'b1;
        tick(1);
        walk = 1'b0;
        checks++; if (ped_urgent !== 1'b0) begin errors++; $display("FAIL age_clear_urg: got %b want 0", ped_urgent); end
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL age_clear_ped: got %b want 0", Pedestrian); end
        raw_ped = 1'b0;
        tick(8);
    endtask

    task automatic test_mid_reset;
        raw_ns  = 1'b0;
        raw_ped = 1'b1;
        tick(6);
        checks++; if (NS !== 1'b0) begin errors++; $display("FAIL mid_ns_fall: got %b want 0", NS); end
        tick(1);
        checks++; if (Pedestrian !== 1'b1) begin errors++; $display("FAIL mid_ped_set: got %b want 1", Pedestrian); end
        raw_ns = 1'b1;
        tick(5);
        checks++; if (NS !== 1'b0) begin errors++; $display("FAIL mid_ns_cnt3: got %b want 0", NS); end
        #2 rst = 1'b0;
        #1;
        checks++; if (EW !== 1'b0) begin errors++; $display("FAIL mid_async_ew: got %b want 0", EW); end
        checks++; if (Pedestrian !== 1'b0) begin errors++; $display("FAIL mid_async_ped: got %b want 0", Pedestrian); end
        checks++; if (NS !== 1'b0) begin errors++; $display("FAIL mid_async_ns: got %b want 0", NS); end
        tick(2);
        rst = 1'b1;
        tick(5);
        checks++; if (NS !== 1'b0) begin errors++; $display("FAIL mid_restart_early: got %b want 0 at edge 5", NS); end
        tick(1);
        checks++; if (NS !== 1'b1) begin errors++; $display("FAIL mid_restart_ns: got %b want 1 at edge 6", NS); end
        checks++; if (EW !== 1'b1) begin errors++; $display("FAIL mid_restart_ew: got %b want 1 at edge 6", EW); end
        tick(1);
        checks++; if (Pedestrian !== 1'b1) begin errors++; $display("FAIL mid_restart_ped: got %b want 1 at edge 7", Pedestrian); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; raw_ns = 1'b0; raw_ew = 1'b0; raw_ped = 1'b0; walk = 1'b0;
        tick(2);
        test_reset();
        test_glitch();
        test_bouncy_button();
        test_collision();
        test_aging();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
